// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int         NUM_CLIENTS_DEF = 4;
  localparam logic [7:0] TO_CNT_MAX      = 8'hFF;

  typedef logic [1:0] client_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Four-way rotating priority encoder: the first requester at or after ptr wins.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [3:0]  req,
  input  client_idx_t ptr,
  output logic        valid,
  output client_idx_t idx
);

  client_idx_t cand;

  // Walk offsets from farthest to nearest so the nearest requester overrides.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + client_idx_t'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Four-client round-robin arbiter in front of a single-word async-ready memory port.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transaction; pick the next requester starting at rr_ptr
// ST_ACCESS | strobes driven; wait for mem_ready or the wait limit
// ST_DONE   | one-cycle completion pulse to the owner; advance rr_ptr
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = NUM_CLIENTS_DEF,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_grant,
  output logic [NUM_CLIENTS-1:0]        cl_done,
  output logic [NUM_CLIENTS-1:0]        cl_err,
  output logic [DATA_W-1:0]             cl_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          mem_we,
  output logic                          mem_oe,
  output logic                          mem_ce,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [1:0]                    owner,
  output logic [7:0]                    timeout_cnt
);

  // Last wait-counter value before the transaction is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e              state_q,    state_d;
  client_idx_t         rr_ptr_q,   rr_ptr_d;
  client_idx_t         owner_q,    owner_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic                we_q,       we_d;
  logic                first_q,    first_d;
  logic                err_q,      err_d;
  logic [7:0]          wait_q,     wait_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic [7:0]          to_cnt_q,   to_cnt_d;

  logic                pick_valid;
  client_idx_t         pick_idx;
  logic [NUM_CLIENTS-1:0] owner_oh;

  rr_picker u_picker (
    .req   (cl_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitration, access wait/timeout, completion.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    first_d  = 1'b0;
    err_d    = err_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    to_cnt_d = to_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          addr_d  = cl_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = cl_wdata[pick_idx*DATA_W +: DATA_W];
          we_d    = cl_we[pick_idx];
          wait_d  = 8'd0;
          first_d = 1'b1;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Ready takes precedence over the wait limit in the same cycle.
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          if (to_cnt_q != TO_CNT_MAX) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = owner_q + client_idx_t'(1);
        err_d    = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= '0;
      rdata_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      first_q  <= first_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign owner_oh    = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << owner_q;
  assign cl_grant    = (state_q == ST_ACCESS && first_q) ? owner_oh : '0;
  assign cl_done     = (state_q == ST_DONE) ? owner_oh : '0;
  assign cl_err      = (state_q == ST_DONE && err_q) ? owner_oh : '0;
  assign cl_rdata    = (state_q == ST_DONE) ? rdata_q : '0;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_ce      = (state_q == ST_ACCESS);
  assign mem_we      = mem_ce & we_q;
  assign mem_oe      = mem_ce & ~we_q;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: stimulus queues expected grants/completions,
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_mem_arbiter_rr;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk;
  logic            reset;
  logic [3:0]      cl_req, cl_we;
  logic [4*AW-1:0] cl_addr;
  logic [4*DW-1:0] cl_wdata;
  logic [3:0]      cl_grant, cl_done, cl_err;
  logic [DW-1:0]   cl_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_we, mem_oe, mem_ce, mem_ready, busy;
  logic [1:0]      owner;
  logic [7:0]      timeout_cnt;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0]  oh;
    logic        err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q_grant[$];
  exp_t q_done[$];

  mem_arbiter_rr #(
    .NUM_CLIENTS    (4),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cl_req      (cl_req),
    .cl_we       (cl_we),
    .cl_addr     (cl_addr),
    .cl_wdata    (cl_wdata),
    .cl_grant    (cl_grant),
    .cl_done     (cl_done),
    .cl_err      (cl_err),
    .cl_rdata    (cl_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_oe      (mem_oe),
    .mem_ce      (mem_ce),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .owner       (owner),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int k, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    cl_we[k]             = we;
    cl_addr[k*AW +: AW]  = a;
    cl_wdata[k*DW +: DW] = d;
  endtask

  function automatic exp_t mk(input logic [3:0] oh, input logic err,
                              input logic [15:0] rd, input int c);
    exp_t e;
    e.oh = oh; e.err = err; e.rdata = rd; e.cyc = c;
    return e;
  endfunction

  // Monitor: compare every grant/completion the arbiter presents against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("oe_decode", 64'(mem_oe), 64'(mem_ce & ~mem_we));
      if (cl_grant != 4'b0) begin
        if (q_grant.size() == 0) begin
          check("grant_unexpected", 64'(cl_grant), 64'd0);
        end else begin
          e = q_grant.pop_front();
          check("grant_onehot", 64'(cl_grant), 64'(e.oh));
          check("grant_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (cl_done != 4'b0) begin
        if (q_done.size() == 0) begin
          check("done_unexpected", 64'(cl_done), 64'd0);
        end else begin
          e = q_done.pop_front();
          check("done_onehot", 64'(cl_done), 64'(e.oh));
          check("done_err", 64'(cl_err), e.err ? 64'(e.oh) : 64'd0);
          check("done_rdata", 64'(cl_rdata), 64'(e.rdata));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (cl_err != 4'b0) begin
        check("err_without_done", 64'(cl_err), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctl"},
          64'({cl_grant, cl_done, cl_err, mem_we, mem_oe, mem_ce, busy, owner, timeout_cnt}),
          64'd0);
    check({name, "_data"}, {cl_rdata, mem_wdata, mem_addr}, 64'd0);
  endtask

  initial begin
    int c;
    reset     = 1'b1;
    cl_req    = '0;
    cl_we     = '0;
    cl_addr   = '0;
    cl_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_held");
    reset = 1'b0;
    tick();
    check_all_zero("reset_released");

    // Single read by client 1, ready in the first ACCESS cycle.
    c = cyc;
    set_client(1, 1'b0, 32'h0000_0040, 16'h0);
    cl_req    = 4'b0010;
    mem_rdata = 16'hBEEF;
    mem_ready = 1'b1;
    q_grant.push_back(mk(4'b0010, 1'b0, 16'h0, c + 1));
    q_done.push_back(mk(4'b0010, 1'b0, 16'hBEEF, c + 2));
    tick();
    cl_req = 4'b0000;
    set_client(1, 1'b1, 32'hDEAD_0000, 16'h5555);
    check("rd_ce", 64'(mem_ce), 64'd1);
    check("rd_oe", 64'(mem_oe), 64'd1);
    check("rd_addr_latched", 64'(mem_addr), 64'h40);
    tick();
    check("rd_done_ce", 64'(mem_ce), 64'd0);
    check("rd_done_oe", 64'(mem_oe), 64'd0);
    tick();
    check("rd_idle_busy", 64'(busy), 64'd0);
    mem_ready = 1'b0;

    // Round robin: all four request, ready tied high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) set_client(k, 1'b0, 32'(k * 16), 16'h0);
    tick();
    c = cyc;
    cl_req    = 4'b1111;
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    for (int k = 0; k < 4; k++) begin
      q_grant.push_back(mk(4'(1 << k), 1'b0, 16'h0, c + 1 + 3 * k));
      q_done.push_back(mk(4'(1 << k), 1'b0, 16'h5A5A, c + 2 + 3 * k));
    end
    q_grant.push_back(mk(4'b0001, 1'b0, 16'h0, c + 13));
    q_done.push_back(mk(4'b0001, 1'b0, 16'h5A5A, c + 14));
    repeat (13) tick();
    cl_req = 4'b0000;
    repeat (3) tick();
    mem_ready = 1'b0;

    // Write by client 2, ready in the fifth ACCESS cycle.
    c = cyc;
    set_client(2, 1'b1, 32'h0000_0100, 16'h1234);
    cl_req    = 4'b0100;
    mem_rdata = 16'hFFFF;
    q_grant.push_back(mk(4'b0100, 1'b0, 16'h0, c + 1));
    q_done.push_back(mk(4'b0100, 1'b0, 16'h0000, c + 6));
    for (int i = 1; i <= 5; i++) begin
      tick();
      cl_req = 4'b0000;
      check("wr_we", 64'(mem_we), 64'd1);
      check("wr_oe", 64'(mem_oe), 64'd0);
      check("wr_mem", {mem_addr, 16'h0, mem_wdata}, {32'h100, 16'h0, 16'h1234});
      if (i == 5) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    check("wr_done_we", 64'(mem_we), 64'd0);
    tick();

    // Timeout: client 3 reads, ready never arrives.
    check("to_cnt_before", 64'(timeout_cnt), 64'd0);
    c = cyc;
    set_client(3, 1'b0, 32'h0000_0300, 16'h0);
    cl_req    = 4'b1000;
    mem_rdata = 16'hA5A5;
    q_grant.push_back(mk(4'b1000, 1'b0, 16'h0, c + 1));
    q_done.push_back(mk(4'b1000, 1'b1, 16'h0000, c + 9));
    for (int i = 1; i <= TO; i++) begin
      tick();
      cl_req = 4'b0000;
      check("to_ce_high", 64'(mem_ce), 64'd1);
    end
    tick();
    check("to_ce_low", 64'(mem_ce), 64'd0);
    check("to_cnt_after", 64'(timeout_cnt), 64'd1);
    tick();

    // Ready and wait limit in the same cycle: ready wins.
    c = cyc;
    set_client(0, 1'b0, 32'h0000_0500, 16'h0);
    cl_req    = 4'b0001;
    mem_rdata = 16'hC0DE;
    q_grant.push_back(mk(4'b0001, 1'b0, 16'h0, c + 1));
    q_done.push_back(mk(4'b0001, 1'b0, 16'hC0DE, c + 9));
    for (int i = 1; i <= TO; i++) begin
      tick();
      cl_req = 4'b0000;
      if (i == TO) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    check("col_to_cnt", 64'(timeout_cnt), 64'd1);
    tick();

    // Reset two cycles into ACCESS, then re-arbitrate with all requesting.
    c = cyc;
    set_client(1, 1'b1, 32'h0000_0700, 16'h7777);
    cl_req = 4'b0010;
    q_grant.push_back(mk(4'b0010, 1'b0, 16'h0, c + 1));
    tick();
    cl_req = 4'b0000;
    tick();
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    tick();
    tick();
    reset = 1'b0;
    c = cyc;
    for (int k = 0; k < 4; k++) set_client(k, 1'b0, 32'h0000_0900, 16'h0);
    cl_req    = 4'b1111;
    mem_ready = 1'b1;
    mem_rdata = 16'h1357;
    q_grant.push_back(mk(4'b0001, 1'b0, 16'h0, c + 1));
    q_done.push_back(mk(4'b0001, 1'b0, 16'h1357, c + 2));
    tick();
    cl_req = 4'b0000;
    check("rst_after_owner", 64'(owner), 64'd0);
    repeat (4) tick();
    mem_ready = 1'b0;

    check("grant_queue_left", 64'(q_grant.size()), 64'd0);
    check("done_queue_left", 64'(q_done.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Four-client round-robin memory arbiter between the accelerator cores (SSI search, ranker, CPU path, reserved) and the external 16-bit asynchronous-ready memory port. It accepts one single-word request at a time, drives the memory strobes until `mem_ready` or a timeout, then returns read data and a completion pulse to the owning client. It is the stage directly downstream of the SSI search and ranker cores and feeds the top-level `mem_*` pins.

## Interface
- `NUM_CLIENTS`, 4, number of requesters; fixed at 4, index width 2.
- `ADDR_W`, 32, memory address width.
- `DATA_W`, 16, memory data width.
- `TIMEOUT_CYCLES`, 255, maximum ACCESS cycles before the arbiter abandons a transaction; legal range 1..255.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `cl_req`  in  NUM_CLIENTS  per-client request level; held until that client's `cl_grant`.
- `cl_we`  in  NUM_CLIENTS  per-client write enable (1 = write).
- `cl_addr`  in  NUM_CLIENTS*ADDR_W  packed addresses; client k at [k*ADDR_W +: ADDR_W].
- `cl_wdata`  in  NUM_CLIENTS*DATA_W  packed write data.
- `cl_grant`  out  NUM_CLIENTS  one-hot single-cycle accept pulse.
- `cl_done`  out  NUM_CLIENTS  one-hot single-cycle completion pulse.
- `cl_err`  out  NUM_CLIENTS  one-hot, coincident with `cl_done`, set on timeout.
- `cl_rdata`  out  DATA_W  shared read data, valid while any `cl_done` bit is high.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wdata`  out  DATA_W  latched write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `mem_we`  out  1  write strobe.
- `mem_oe`  out  1  output enable = `mem_ce & ~mem_we`.
- `mem_ce`  out  1  chip enable; high only in ACCESS.
- `mem_ready`  in  1  memory completion; honoured only in ACCESS.
- `busy`  out  1  high when state != IDLE.
- `owner`  out  2  index of current/last owner.
- `timeout_cnt`  out  8  saturating count of timed-out transactions.

## Operation
- States: IDLE, ACCESS, DONE. Encodings come from the package; the default arm returns to IDLE.
- IDLE: if any `cl_req`, select the winner with the rotating priority described below. Latch its addr/wdata/we and `owner`, clear the wait counter, and go to ACCESS.
- Rotating priority: search starts at `rr_ptr`, then `rr_ptr+1` mod 4, and so on.
- ACCESS, first cycle: `cl_grant[owner]` = 1 for exactly this cycle.
- ACCESS, every cycle: `mem_ce` = 1 and `mem_we` = latched we.
  - If `mem_ready` is high: for a read, capture `mem_rdata` into the rdata register; for a write, load 0. Go to DONE.
  - Else if the wait counter equals `TIMEOUT_CYCLES-1`: load rdata = 0, set the err flag, increment `timeout_cnt` (saturating at 255), and go to DONE.
  - Else increment the wait counter.
- DONE: `cl_done[owner]` = 1 and `cl_err[owner]` = err flag; strobes are low. Set `rr_ptr` = owner+1 mod 4, clear the err flag, and go to IDLE.
- A client still holding `cl_req` after its `cl_done` is re-arbitrated normally. Because of the rotation, every other pending client is served before it again.
- Changes to `cl_req`, `cl_addr`, `cl_wdata` or `cl_we` after the grant have no effect on the transaction in flight.
- Asynchronous reset mid-transaction: the state returns to IDLE immediately and nothing completes. The client gets no `cl_done` and must reissue.

## Timing
- Reset values: all outputs 0. Internally `rr_ptr`=0, state IDLE, `timeout_cnt`=0, rdata=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `mem_ready` or `cl_*` to any output.
- Request at edge N (IDLE): ACCESS from N+1, with `cl_grant` and the first `mem_ce` cycle coinciding.
- `mem_ready` sampled high at edge M: DONE during M+1, IDLE at M+2.
- Minimum transaction (`mem_ready` high in the first ACCESS cycle) is 3 cycles. Maximum back-to-back throughput is one transaction per 3 cycles.
- Timeout path: exactly `TIMEOUT_CYCLES` ACCESS cycles, then DONE.
- `mem_ready` and the timeout in the same cycle: `mem_ready` wins and no error is flagged.

## Structure
- Package `mem_arb_pkg`: the state enum (IDLE/ACCESS/DONE), the 2-bit client index type, `NUM_CLIENTS` default, and the `timeout_cnt` saturation constant 8'hFF.
- Sub-module `rr_picker`: combinational 4-way rotating priority encoder. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `valid` and `idx[1:0]`. The FSM, the latches and the counters stay in the top module.

## Test plan
- Single read: client 1 reads addr 0x0000_0040; memory returns 0xBEEF with `mem_ready` in the first ACCESS cycle. Expect `cl_grant`=0010 at N+1, `cl_done`=0010 with `cl_rdata`=0xBEEF at N+2, `mem_oe`=1 only in ACCESS.
- Round robin: all four `cl_req` held high, `mem_ready` tied high. Expect grant order 0,1,2,3,0 with one grant every 3 cycles.
- Write: client 2 writes 0x1234 to 0x100, with `mem_ready` asserted 5 cycles into ACCESS. Expect `mem_we`=1 and `mem_oe`=0 for 5 cycles, then `cl_done`=0100 with `cl_rdata`=0.
- Timeout: `TIMEOUT_CYCLES`=8, `mem_ready` held low, client 3 reads. Expect `mem_ce` high for exactly 8 cycles, then `cl_done`=`cl_err`=1000, and `timeout_cnt` going 0→1.
- Ready/timeout collision: `mem_ready` arrives in ACCESS cycle 8 with `TIMEOUT_CYCLES`=8. Expect the data captured and `cl_err`=0.
- Reset mid-ACCESS: assert `reset` 2 cycles into ACCESS. Expect all outputs 0 immediately and no `cl_done`. After release, the next arbitration with requests 1111 picks client 0.
